gate_sweep_controller: RTL and testbench
========================================

// Module: gate_sweep_controller
// PURPOSE
//  Drives the operand (sw[1:0]) and select (sw[4:2]) inputs of combinational_gates_muxed
//  and samples its led output, sweeping all 8 gate selects x 4 operand pairs.
//  Captures a 32-bit truth table of the gate bank, with start/busy/done handshake.
//  Sits between the board-level start button logic and the gate bank; table_out feeds the display.
// PARAMETERS
//  SETTLE_CYCLES  4  cycles the driven inputs are held before sampling gate_in (legal range 1..255)
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   request a sweep; accepted only in IDLE
//  gate_in    in   1   led output of the gate bank
//  op_a       out  1   to gate bank sw[0]
//  op_b       out  1   to gate bank sw[1]
//  sel        out  3   to gate bank sw[4:2]
//  busy       out  1   high from the cycle after start is accepted until DONE
//  done       out  1   one-cycle pulse; sweep complete, table_out valid
//  table_out  out  32  captured table; bit {sel,op_b,op_a} = gate output for that point
//  mismatch   out  1   (GATE_SWEEP_CHECK_EN only) sticky; a sample differed from golden
//  mm_idx     out  5   (GATE_SWEEP_CHECK_EN only) index of the first mismatching sample
// BEHAVIOUR
//  Reset: state=IDLE; idx=0; op_a/op_b/sel=0; busy=done=0; table_out=0; mismatch=0; mm_idx=0.
//  idx[4:0] = {sel,op_b,op_a}. Outputs are registered from idx. Order is idx 0..31 (op_a fastest, sel slowest).
//  FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
//   IDLE:   start=1 -> DRIVE; idx<=0; table_out<=0; mismatch/mm_idx<=0; busy<=1.
//   DRIVE:  1 cycle; {sel,op_b,op_a}<=idx; settle count<=SETTLE_CYCLES-1 -> SETTLE.
//   SETTLE: decrement; at count 0 -> SAMPLE. Exactly SETTLE_CYCLES cycles in this state.
//   SAMPLE: table_out[idx]<=gate_in; idx==31 -> DONE, else idx<=idx+1 -> DRIVE.
//   DONE:   done=1 for this single cycle; busy<=0 -> IDLE. table_out holds until the next accept.
//  Latency: start accepted at edge T -> done high in cycle T+32*(SETTLE_CYCLES+2)+1.
//  start is ignored while busy (no queuing). start held high in IDLE re-triggers after DONE.
//  op_a/op_b/sel hold the last driven point (idx 31 = 3'b111,1,1) after a sweep until the next DRIVE.
//  idx does not wrap; the 31->DONE transition is the only exit from the sweep.
//  rst asserted mid-sweep: all state returns to reset values on that edge; partial table discarded.
// CONFIGURATION
//  `define GATE_SWEEP_CHECK_EN: in SAMPLE, compare gate_in with GOLDEN_TABLE[idx]. On the first
//   difference set mismatch=1 and mm_idx=idx. Later differences leave mm_idx unchanged. Both are
//   cleared on start accept. The sweep always runs to completion.
//  Without the macro: mismatch/mm_idx ports, compare logic and golden constant are absent.
// STRUCTURE
//  Shared header gate_sweep_pkg.vh (`include):
//   - state encodings S_IDLE..S_DONE (3 bits)
//   - IDX_W=5
//   - GOLDEN_TABLE = 32'h781E69A5, nibbles sel7..sel0 = NAND 7, AND 8, NOR 1, OR E, XOR 6,
//     XNOR 9, BUF A, NOT 5
//  Sub-module gate_sweep_settle_timer: load/decrement down-counter with zero flag, width 8.
// TESTING (bench instantiates this block + combinational_gates_muxed, SETTLE_CYCLES=4)
//  1. rst 2 cycles, no start -> all outputs 0 and state IDLE for 20 cycles.
//  2. start pulse 1 cycle -> busy next cycle; done pulse exactly 193 cycles after accept;
//     table_out=32'h781E69A5.
//  3. Pulse start at cycles 10 and 50 of a sweep -> ignored; single done; table unchanged.
//  4. rst at cycle 60 of a sweep -> next cycle table_out=0, busy=0, sel=0. A new start completes
//     normally with the correct table.
//  5. CHECK_EN on, bench forces gate_in to 0 at idx 6 and 20 -> mismatch=1, mm_idx=6 at done.
//     Next start clears both.
//  6. start held high continuously -> back-to-back sweeps, one idle cycle between done and the
//     next accept.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep controller and its settle timer.
// GOLDEN_TABLE exists only when GATE_SWEEP_CHECK_EN is defined.
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int IDX_W   = 5;
    localparam int TABLE_W = 1 << IDX_W;
    localparam int TIMER_W = 8;

    localparam logic [IDX_W-1:0] IDX_LAST = 5'd31;

`ifdef GATE_SWEEP_CHECK_EN
    // Nibbles sel7..sel0: NAND, AND, NOR, OR, XOR, XNOR, BUF A, NOT A
    localparam logic [TABLE_W-1:0] GOLDEN_TABLE = 32'h781E69A5;
`endif

endpackage

// File: rtl/gate_sweep_settle_timer.sv
// Loadable down-counter with zero flag; sets how long driven inputs settle before sampling.
module gate_sweep_settle_timer
    import gate_sweep_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/gate_sweep_controller.sv
// Sweeps the 32 {sel,op_b,op_a} points of a gate bank and captures its truth table.
// Define GATE_SWEEP_CHECK_EN to add golden-table comparison (mismatch / mm_idx ports).
module gate_sweep_controller
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               gate_in,
    output logic               op_a,
    output logic               op_b,
    output logic [2:0]         sel,
    output logic               busy,
    output logic               done,
`ifdef GATE_SWEEP_CHECK_EN
    output logic               mismatch,
    output logic [IDX_W-1:0]   mm_idx,
`endif
    output logic [TABLE_W-1:0] table_out
);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               op_a_reg, op_b_reg;
    logic [2:0]         sel_reg;
    logic               busy_reg;
    logic [TABLE_W-1:0] table_reg;

    logic accept, timer_load, timer_dec, timer_zero, sample_en, done_next;

    gate_sweep_settle_timer #(.W(TIMER_W)) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (TIMER_W'(SETTLE_CYCLES - 1)),
        .zero     (timer_zero)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        sample_en  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                timer_load = 1'b1;
                state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (timer_zero) begin
                    state_next = S_SAMPLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            S_SAMPLE: begin
                sample_en  = 1'b1;
                state_next = (idx_reg == IDX_LAST) ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            op_a_reg  <= 1'b0;
            op_b_reg  <= 1'b0;
            sel_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                idx_reg  <= '0;
                busy_reg <= 1'b1;
            end
            if (state_reg == S_DRIVE) begin
                {sel_reg, op_b_reg, op_a_reg} <= idx_reg;
            end
            // idx stops at 31; leaving the sweep is handled by the DONE transition
            if (sample_en && (idx_reg != IDX_LAST)) begin
                idx_reg <= idx_reg + 1'b1;
            end
            if (done_next) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // One capture flop per table entry, written only when the sweep samples its index
    generate
        for (genvar gi = 0; gi < TABLE_W; gi++) begin : g_table
            always_ff @(posedge clk) begin
                if (rst || accept) begin
                    table_reg[gi] <= 1'b0;
                end else if (sample_en && (idx_reg == IDX_W'(gi))) begin
                    table_reg[gi] <= gate_in;
                end
            end
        end
    endgenerate

`ifdef GATE_SWEEP_CHECK_EN
    logic             mismatch_reg;
    logic [IDX_W-1:0] mm_idx_reg;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            mismatch_reg <= 1'b0;
            mm_idx_reg   <= '0;
        end else if (sample_en && !mismatch_reg && (gate_in != GOLDEN_TABLE[idx_reg])) begin
            mismatch_reg <= 1'b1;
            mm_idx_reg   <= idx_reg;
        end
    end

    assign mismatch = mismatch_reg;
    assign mm_idx   = mm_idx_reg;
`endif

    assign op_a      = op_a_reg;
    assign op_b      = op_b_reg;
    assign sel       = sel_reg;
    assign busy      = busy_reg;
    assign done      = done_next;
    assign table_out = table_reg;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Directed bench for gate_sweep_controller driving a behavioural 8-gate bank.
// Define GATE_SWEEP_CHECK_EN to also exercise the golden-table mismatch reporting.
module tb_gate_sweep_controller;
    import gate_sweep_pkg::*;

    localparam logic [31:0] EXP_TABLE     = 32'h781E69A5;
    localparam logic [31:0] EXP_CORRUPTED = 32'h780E69E5;  // bits 6 and 20 inverted
    localparam int          EXP_LATENCY   = 192;           // edges after the accept edge

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        gate_in;
    logic        op_a, op_b;
    logic [2:0]  sel;
    logic        busy, done;
    logic [31:0] table_out;
    logic        corrupt = 1'b0;
    logic        gate_model;
`ifdef GATE_SWEEP_CHECK_EN
    logic        mismatch;
    logic [4:0]  mm_idx;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gate_sweep_controller #(.SETTLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gate_in   (gate_in),
        .op_a      (op_a),
        .op_b      (op_b),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
`ifdef GATE_SWEEP_CHECK_EN
        .mismatch  (mismatch),
        .mm_idx    (mm_idx),
`endif
        .table_out (table_out)
    );

    // Gate bank: sel 0..7 = NOT A, BUF A, XNOR, XOR, OR, NOR, AND, NAND
    always_comb begin
        gate_model = 1'b0;
        case (sel)
            3'd0: gate_model = ~op_a;
            3'd1: gate_model = op_a;
            3'd2: gate_model = ~(op_a ^ op_b);
            3'd3: gate_model = op_a ^ op_b;
            3'd4: gate_model = op_a | op_b;
            3'd5: gate_model = ~(op_a | op_b);
            3'd6: gate_model = op_a & op_b;
            3'd7: gate_model = ~(op_a & op_b);
            default: gate_model = 1'b0;
        endcase
    end

    assign gate_in = gate_model ^ (corrupt && (({sel, op_b, op_a} == 5'd6) ||
                                               ({sel, op_b, op_a} == 5'd20)));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else begin
            pass_cnt++;
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Raise start for one edge; returns at the negedge after the accept edge.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
    endtask

    // From the negedge after the accept edge, count edges until done; -1 on timeout.
    // With extra_starts set, start is pulsed during sweep cycles 10 and 50.
    task automatic wait_done(input bit extra_starts, output int k);
        k = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (extra_starts) start = (n == 10 || n == 50);
            if (done === 1'b1) begin
                k = n;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            total_cnt++;
            if ({busy, done, op_a, op_b, sel, table_out} !== 38'd0 || dut.state_reg !== S_IDLE) begin
                $display("FAIL reset_idle cycle %0d: got busy=%b done=%b sel=%0d table=%h state=%0d expected all zero, IDLE",
                         n, busy, done, sel, table_out, dut.state_reg);
            end else pass_cnt++;
        end
        $display("ok   reset_idle: 20 idle cycles checked");
    endtask

    task automatic test_sweep();
        int k;
        pulse_start();
        check("sweep_busy_after_accept", 64'(busy), 64'd1);
        wait_done(1'b0, k);
        check("sweep_latency", 64'(k), 64'(EXP_LATENCY));
        check("sweep_table", 64'(table_out), 64'(EXP_TABLE));
        check("sweep_last_point", 64'({sel, op_b, op_a}), 64'd31);
        @(negedge clk);
        check("sweep_done_single_pulse", 64'({done, busy}), 64'd0);
    endtask

    task automatic test_start_while_busy();
        int k;
        int extra_dones = 0;
        pulse_start();
        wait_done(1'b1, k);
        check("busy_ignore_latency", 64'(k), 64'(EXP_LATENCY));
        check("busy_ignore_table", 64'(table_out), 64'(EXP_TABLE));
        repeat (250) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_dones++;
        end
        check("busy_ignore_no_requeue", 64'(extra_dones), 64'd0);
    endtask

    task automatic test_mid_sweep_reset();
        int k;
        pulse_start();
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("midrst_table", 64'(table_out), 64'd0);
        check("midrst_busy_sel", 64'({busy, sel}), 64'd0);
        check("midrst_state", 64'(dut.state_reg), 64'(S_IDLE));
        pulse_start();
        wait_done(1'b0, k);
        check("midrst_resweep_latency", 64'(k), 64'(EXP_LATENCY));
        check("midrst_resweep_table", 64'(table_out), 64'(EXP_TABLE));
    endtask

`ifdef GATE_SWEEP_CHECK_EN
    task automatic test_check_en();
        int k;
        corrupt = 1'b1;
        pulse_start();
        wait_done(1'b0, k);
        check("chk_latency", 64'(k), 64'(EXP_LATENCY));
        check("chk_mismatch", 64'(mismatch), 64'd1);
        check("chk_mm_idx", 64'(mm_idx), 64'd6);
        check("chk_table", 64'(table_out), 64'(EXP_CORRUPTED));
        corrupt = 1'b0;
        @(negedge clk);
        pulse_start();
        check("chk_clear_on_accept", 64'({mismatch, mm_idx}), 64'd0);
        wait_done(1'b0, k);
        check("chk_clean_mismatch", 64'(mismatch), 64'd0);
    endtask
`endif

    task automatic test_back_to_back();
        int k;
        @(negedge clk) start = 1'b1;
        k = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                k = n;
                break;
            end
        end
        check("b2b_first_done_seen", 64'(k > 0), 64'd1);
        @(negedge clk);
        check("b2b_idle_gap", 64'({done, busy}), 64'd0);
        @(negedge clk);
        check("b2b_reaccept_busy", 64'(busy), 64'd1);
        k = -1;
        for (int n = 3; n <= 400; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                k = n;
                break;
            end
        end
        start = 1'b0;
        check("b2b_done_to_done", 64'(k), 64'(EXP_LATENCY + 2));
        check("b2b_table", 64'(table_out), 64'(EXP_TABLE));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_start_while_busy();
        test_mid_sweep_reset();
`ifdef GATE_SWEEP_CHECK_EN
        test_check_en();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
